// File: rtl/imem_fetch_sequencer.sv
// Instruction-fetch sequencer: owns the fetch PC, captures each word returned
// by the combinational instruction memory into a small circular queue, and
// presents the queue head to the IF/ID register. Handles ID back-pressure,
// branch redirects (queue flush) and sticky faults on illegal fetch PCs.
module imem_fetch_sequencer #(
   parameter logic [63:0] RESET_PC   = 64'd0,
   parameter int unsigned IMEM_BYTES = 20,
   parameter int unsigned DEPTH      = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic [63:0] Inst_Address,
   input  logic [31:0] Instruction,
   input  logic        Branch_Taken,
   input  logic [63:0] Branch_Target,
   input  logic        ID_Ready,
   output logic        IF_Valid,
   output logic [31:0] IF_Instruction,
   output logic [63:0] IF_PC,
   output logic        Fetch_Fault
);

   localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [64:0] MEM_END  = 65'(IMEM_BYTES);

   typedef enum logic {RUN = 1'b0, FAULT = 1'b1} state_t;

   state_t          state;
   logic [63:0]     fetch_pc;
   logic [31:0]     q_inst [DEPTH];
   logic [63:0]     q_pc   [DEPTH];
   logic [AW-1:0]   rd_ptr;
   logic [AW-1:0]   wr_ptr;
   logic [AW:0]     count;

   logic [64:0]     pc_end;
   logic            legal;
   logic            full;
   logic            pop;
   logic            push;

   // End address is formed at 65 bits so a PC near 2^64 cannot wrap into range.
   assign pc_end = {1'b0, fetch_pc} + 65'd4;
   assign legal  = (fetch_pc[1:0] == 2'b00) && (pc_end <= MEM_END);
   assign full   = (count == FULL_CNT);
   assign pop    = IF_Valid & ID_Ready;
   // A full queue still accepts a word when the head leaves in the same cycle.
   assign push   = (state == RUN) && !Branch_Taken && legal && (!full || pop);

   assign Inst_Address   = fetch_pc;
   assign IF_Valid       = (count != '0);
   assign IF_Instruction = q_inst[rd_ptr];
   assign IF_PC          = q_pc[rd_ptr];

   // Fetch FSM: redirect beats fault detection, which beats normal advance.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= RUN;
         fetch_pc    <= RESET_PC;
         Fetch_Fault <= 1'b0;
      end else if (Branch_Taken) begin
         state       <= RUN;
         fetch_pc    <= Branch_Target;
         Fetch_Fault <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (!legal) begin
                  state       <= FAULT;
                  Fetch_Fault <= 1'b1;
               end else if (push) begin
                  fetch_pc <= fetch_pc + 64'd4;
               end
            end
            FAULT: begin
               Fetch_Fault <= 1'b1;
            end
            default: begin
               state <= RUN;
            end
         endcase
      end
   end

   // Queue bookkeeping; a redirect empties the queue and drops any same-cycle pop.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (Branch_Taken) begin
         rd_ptr <= wr_ptr;
         count  <= '0;
      end else begin
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (push && !pop)      count <= count + (AW+1)'(1);
         else if (pop && !push) count <= count - (AW+1)'(1);
      end
   end

   // Entry storage, cleared on reset so the head never reads as X.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            q_inst[i] <= '0;
            q_pc[i]   <= '0;
         end
      end else if (push) begin
         q_inst[wr_ptr] <= Instruction;
         q_pc[wr_ptr]   <= fetch_pc;
      end
   end

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Bench for imem_fetch_sequencer: directed scenarios from the test plan plus a
// randomized run against a queue-based reference model.
module tb_imem_fetch_sequencer;

   logic        clk;
   logic        reset;
   logic [63:0] Inst_Address;
   logic [31:0] Instruction;
   logic        Branch_Taken;
   logic [63:0] Branch_Target;
   logic        ID_Ready;
   logic        IF_Valid;
   logic [31:0] IF_Instruction;
   logic [63:0] IF_PC;
   logic        Fetch_Fault;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [31:0] mem [0:4];

   imem_fetch_sequencer #(.RESET_PC(64'd0), .IMEM_BYTES(20), .DEPTH(2)) dut (
      .clk(clk), .reset(reset), .Inst_Address(Inst_Address), .Instruction(Instruction),
      .Branch_Taken(Branch_Taken), .Branch_Target(Branch_Target), .ID_Ready(ID_Ready),
      .IF_Valid(IF_Valid), .IF_Instruction(IF_Instruction), .IF_PC(IF_PC),
      .Fetch_Fault(Fetch_Fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Combinational instruction memory.
   always_comb begin
      Instruction = 32'hBAD0_0BAD;
      if (Inst_Address < 64'd20 && Inst_Address[1:0] == 2'b00)
         Instruction = mem[Inst_Address[4:2]];
   end

   function automatic logic [31:0] img(input logic [63:0] a);
      return mem[a[4:2]];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset         = 1'b0;
      Branch_Taken  = 1'b0;
      Branch_Target = 64'd0;
      ID_Ready      = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      Branch_Taken = 1'b0; Branch_Target = 64'd0; ID_Ready = 1'b1;
      tick();
      n_cmp++; if (IF_Valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", IF_Valid); end
      n_cmp++; if (Inst_Address !== 64'd0) begin n_fail++; $display("FAIL reset_addr got %0h want 0", Inst_Address); end
      n_cmp++; if (Fetch_Fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault got %0b want 0", Fetch_Fault); end
      n_cmp++; if (IF_PC !== 64'd0 || IF_Instruction !== 32'd0) begin n_fail++; $display("FAIL reset_head got %0h/%0h want 0/0", IF_PC, IF_Instruction); end
      reset = 1'b1;
   endtask

   task automatic test_straight();
      do_reset();
      ID_Ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_cmp++;
         if (IF_Valid !== 1'b1 || IF_PC !== 64'(i*4) || IF_Instruction !== mem[i]) begin
            n_fail++;
            $display("FAIL straight_%0d got v=%0b pc=%0h ins=%0h want v=1 pc=%0h ins=%0h",
                     i, IF_Valid, IF_PC, IF_Instruction, i*4, mem[i]);
         end
      end
      tick();
      n_cmp++;
      if (IF_Valid !== 1'b0 || Fetch_Fault !== 1'b1 || Inst_Address !== 64'd20) begin
         n_fail++;
         $display("FAIL straight_end got v=%0b f=%0b a=%0h want v=0 f=1 a=14", IF_Valid, Fetch_Fault, Inst_Address);
      end
   endtask

   task automatic test_stall();
      do_reset();
      ID_Ready = 1'b0;
      tick();
      tick();
      tick();
      n_cmp++;
      if (Inst_Address !== 64'd8 || IF_PC !== 64'd0 || IF_Valid !== 1'b1) begin
         n_fail++;
         $display("FAIL stall_hold got a=%0h pc=%0h v=%0b want a=8 pc=0 v=1", Inst_Address, IF_PC, IF_Valid);
      end
      ID_Ready = 1'b1;
      for (int i = 1; i < 3; i++) begin
         tick();
         n_cmp++;
         if (IF_Valid !== 1'b1 || IF_PC !== 64'(i*4) || IF_Instruction !== mem[i]) begin
            n_fail++;
            $display("FAIL stall_drain_%0d got v=%0b pc=%0h want v=1 pc=%0h", i, IF_Valid, IF_PC, i*4);
         end
      end
   endtask

   task automatic test_redirect();
      do_reset();
      ID_Ready = 1'b1;
      tick();
      tick();
      ID_Ready = 1'b0;
      tick();
      n_cmp++;
      if (IF_PC !== 64'd4 || Inst_Address !== 64'd12) begin
         n_fail++;
         $display("FAIL redir_setup got pc=%0h a=%0h want pc=4 a=c", IF_PC, Inst_Address);
      end
      ID_Ready = 1'b1; Branch_Taken = 1'b1; Branch_Target = 64'd12;
      tick();
      Branch_Taken = 1'b0;
      n_cmp++;
      if (IF_Valid !== 1'b0 || Inst_Address !== 64'd12) begin
         n_fail++;
         $display("FAIL redir_bubble got v=%0b a=%0h want v=0 a=c", IF_Valid, Inst_Address);
      end
      tick();
      n_cmp++;
      if (IF_Valid !== 1'b1 || IF_PC !== 64'd12 || IF_Instruction !== 32'h02953423) begin
         n_fail++;
         $display("FAIL redir_first got v=%0b pc=%0h ins=%0h want v=1 pc=c ins=02953423", IF_Valid, IF_PC, IF_Instruction);
      end
      tick();
      n_cmp++;
      if (IF_Valid !== 1'b1 || IF_PC !== 64'd16) begin
         n_fail++;
         $display("FAIL redir_second got v=%0b pc=%0h want v=1 pc=10", IF_Valid, IF_PC);
      end
   endtask

   task automatic test_fault_recovery();
      do_reset();
      ID_Ready = 1'b1;
      for (int i = 0; i < 8; i++) tick();
      n_cmp++;
      if (Fetch_Fault !== 1'b1 || IF_Valid !== 1'b0 || Inst_Address !== 64'd20) begin
         n_fail++;
         $display("FAIL fault_sticky got f=%0b v=%0b a=%0h want f=1 v=0 a=14", Fetch_Fault, IF_Valid, Inst_Address);
      end
      Branch_Taken = 1'b1; Branch_Target = 64'd4;
      tick();
      Branch_Taken = 1'b0;
      n_cmp++;
      if (Fetch_Fault !== 1'b0 || IF_Valid !== 1'b0) begin
         n_fail++;
         $display("FAIL fault_clear got f=%0b v=%0b want f=0 v=0", Fetch_Fault, IF_Valid);
      end
      tick();
      n_cmp++;
      if (IF_Valid !== 1'b1 || IF_PC !== 64'd4 || IF_Instruction !== 32'h009A84B3) begin
         n_fail++;
         $display("FAIL fault_resume got v=%0b pc=%0h ins=%0h want v=1 pc=4 ins=009a84b3", IF_Valid, IF_PC, IF_Instruction);
      end
   endtask

   task automatic test_misaligned();
      Branch_Taken = 1'b1; Branch_Target = 64'd6; ID_Ready = 1'b1;
      tick();
      Branch_Taken = 1'b0;
      n_cmp++;
      if (Fetch_Fault !== 1'b0 || IF_Valid !== 1'b0 || Inst_Address !== 64'd6) begin
         n_fail++;
         $display("FAIL misal_redir got f=%0b v=%0b a=%0h want f=0 v=0 a=6", Fetch_Fault, IF_Valid, Inst_Address);
      end
      tick();
      n_cmp++;
      if (Fetch_Fault !== 1'b1 || IF_Valid !== 1'b0) begin
         n_fail++;
         $display("FAIL misal_fault got f=%0b v=%0b want f=1 v=0", Fetch_Fault, IF_Valid);
      end
      tick();
      n_cmp++;
      if (Fetch_Fault !== 1'b1 || IF_Valid !== 1'b0 || Inst_Address !== 64'd6) begin
         n_fail++;
         $display("FAIL misal_hold got f=%0b v=%0b a=%0h want f=1 v=0 a=6", Fetch_Fault, IF_Valid, Inst_Address);
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      ID_Ready = 1'b0;
      tick();
      tick();
      n_cmp++;
      if (IF_Valid !== 1'b1 || Inst_Address !== 64'd8) begin
         n_fail++;
         $display("FAIL midrst_full got v=%0b a=%0h want v=1 a=8", IF_Valid, Inst_Address);
      end
      #2;
      reset = 1'b0;
      #1;
      n_cmp++;
      if (IF_Valid !== 1'b0 || Inst_Address !== 64'd0 || IF_PC !== 64'd0 || IF_Instruction !== 32'd0) begin
         n_fail++;
         $display("FAIL midrst_async got v=%0b a=%0h pc=%0h ins=%0h want all 0", IF_Valid, Inst_Address, IF_PC, IF_Instruction);
      end
      tick();
      reset = 1'b1;
      ID_Ready = 1'b1;
      tick();
      n_cmp++;
      if (IF_Valid !== 1'b1 || IF_PC !== 64'd0 || IF_Instruction !== 32'h02853483) begin
         n_fail++;
         $display("FAIL midrst_restart got v=%0b pc=%0h want v=1 pc=0", IF_Valid, IF_PC);
      end
   endtask

   task automatic test_random();
      logic [63:0] mq_pc [$];
      logic [31:0] mq_in [$];
      logic [63:0] mpc;
      logic        mflt;
      logic [63:0] targets [0:9];
      logic        br;
      logic        rdy;
      logic [63:0] tgt;
      targets = '{64'd0, 64'd4, 64'd8, 64'd12, 64'd16, 64'd20, 64'd6, 64'd2, 64'd24, 64'hFFFF_FFFF_FFFF_FFFC};
      do_reset();
      mpc = 64'd0; mflt = 1'b0;
      for (int c = 0; c < 600; c++) begin
         br  = ($urandom_range(7) == 0);
         tgt = targets[$urandom_range(9)];
         rdy = 1'($urandom_range(1));
         Branch_Taken = br; Branch_Target = tgt; ID_Ready = rdy;
         if (br) begin
            mq_pc.delete(); mq_in.delete();
            mpc = tgt; mflt = 1'b0;
         end else begin
            if (mq_pc.size() > 0 && rdy) begin
               void'(mq_pc.pop_front());
               void'(mq_in.pop_front());
            end
            if (!mflt) begin
               if (mpc[1:0] != 2'b00 || ({1'b0, mpc} + 65'd4 > 65'd20)) mflt = 1'b1;
               else if (mq_pc.size() < 2) begin
                  mq_pc.push_back(mpc);
                  mq_in.push_back(img(mpc));
                  mpc = mpc + 64'd4;
               end
            end
         end
         tick();
         n_cmp++;
         if (IF_Valid !== (mq_pc.size() != 0) || Fetch_Fault !== mflt || Inst_Address !== mpc) begin
            n_fail++;
            $display("FAIL rand_%0d ctl got v=%0b f=%0b a=%0h want v=%0b f=%0b a=%0h",
                     c, IF_Valid, Fetch_Fault, Inst_Address, (mq_pc.size() != 0), mflt, mpc);
         end else if (mq_pc.size() != 0) begin
            n_cmp++;
            if (IF_PC !== mq_pc[0] || IF_Instruction !== mq_in[0]) begin
               n_fail++;
               $display("FAIL rand_%0d head got pc=%0h ins=%0h want pc=%0h ins=%0h",
                        c, IF_PC, IF_Instruction, mq_pc[0], mq_in[0]);
            end
         end
      end
      Branch_Taken = 1'b0;
   endtask

   initial begin
      mem[0] = 32'h02853483;
      mem[1] = 32'h009A84B3;
      mem[2] = 32'h00148493;
      mem[3] = 32'h02953423;
      mem[4] = 32'h02853483;
      reset = 1'b0; Branch_Taken = 1'b0; Branch_Target = 64'd0; ID_Ready = 1'b0;
      test_reset();
      test_straight();
      test_stall();
      test_redirect();
      test_fault_recovery();
      test_misaligned();
      test_mid_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
